// File: rtl/avalon_st_pkt_source_pkg.sv
// Shared definitions for the Avalon-ST packet source: FSM encodings and a
// constant-function log2 used to size pointers and counters.
package avalon_st_pkt_source_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_sync_fifo.sv
// Single-clock FIFO with a combinational head read. A write that coincides
// with a pop is accepted even when full, since the pop frees the slot.
module avalon_sync_fifo
  import avalon_st_pkt_source_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              empty;
  logic              do_rd;
  logic              do_wr;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/avalon_st_pkt_source.sv
// Avalon-ST packet source (ready latency 0): streams pkt_len words from the
// internal FIFO as one sop/eop framed packet per accepted start.
module avalon_st_pkt_source
  import avalon_st_pkt_source_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  input  logic              start,
  input  logic [CNT_W-1:0]  pkt_len,
  output logic              busy,
  output logic              done,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              sop,
  output logic              eop,
  output logic [0:0]        state_dbg
);

  // Handshake: a beat moves on a rising edge with valid && ready. Once valid
  // rises, valid/data/sop/eop are frozen until that beat has moved.

  logic [0:0]        state;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] head;
  logic              accept;
  logic              xfer;
  logic              pop;

  assign state_dbg = state;

  // The length check against count is what rules out FIFO underrun.
  assign accept = (state == ST_IDLE) && start &&
                  (pkt_len != '0) && (pkt_len <= count);
  assign xfer   = (state == ST_SEND) && valid && ready;
  assign pop    = accept || (xfer && !eop);

  avalon_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      remaining <= '0;
      valid     <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      data      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            remaining <= pkt_len;
            data      <= head;
            valid     <= 1'b1;
            sop       <= 1'b1;
            eop       <= (pkt_len == CNT_W'(1));
            busy      <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (eop) begin
              valid <= 1'b0;
              sop   <= 1'b0;
              eop   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              // remaining counts the beat on the bus, so 2 means the next one is last.
              data      <= head;
              sop       <= 1'b0;
              eop       <= (remaining == CNT_W'(2));
              remaining <= remaining - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/avalon_st_pkt_source.md
Name: avalon_st_pkt_source

Overview:
- Parametrised Avalon-Streaming source, ready latency 0.
- Replaces the fixed three-word sender.
- Payload words are loaded through a write port into an internal FIFO. A start command then streams a programmable-length packet with startofpacket/endofpacket framing.
- Sits between a control/CPU-side loader and any Avalon-ST sink in the design.

Parameters:
- DATA_W, 8, width of each data beat.
- DEPTH, 16, FIFO capacity in words; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the count and length fields.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  DATA_W  payload word
- full  out  1  FIFO holds DEPTH words
- count  out  CNT_W  words currently stored
- start  in  1  request one packet (1-cycle pulse or level)
- pkt_len  in  CNT_W  beats in the requested packet, sampled when start is accepted
- busy  out  1  packet in progress
- done  out  1  one-cycle pulse after the eop beat transfers
- valid  out  1  Avalon-ST valid
- ready  in  1  Avalon-ST ready (sink)
- data  out  DATA_W  Avalon-ST data
- sop  out  1  startofpacket
- eop  out  1  endofpacket

Behaviour:
- Reset (async assert, sync release): valid=0, sop=0, eop=0, data=0, busy=0, done=0, FIFO emptied (count=0, full=0), FSM in IDLE.
- Reset mid-packet aborts the packet immediately. The remaining FIFO contents are discarded.
- A beat transfers on a rising edge where valid && ready.
- While valid=1 and ready=0, data, sop and eop hold stable. valid never drops before its beat transfers.
- FSM states:
  - IDLE:
    - start is accepted only when pkt_len>=1 and pkt_len<=count.
    - A start with pkt_len=0 or pkt_len>count is ignored: no state change, no done.
    - On acceptance: latch pkt_len into remaining counter, pop the FIFO head into data, set valid=1, sop=1, eop=(pkt_len==1), busy=1, go to SEND.
    - The first beat is visible the cycle after the accepting edge (latency 1).
  - SEND:
    - On each transfer that is not the last, pop the next word into data on the same edge (no bubbles), sop=0, decrement remaining, eop=1 when the new beat is the last.
    - On transfer of the eop beat: valid=0, sop=0, eop=0, busy=0, done=1 for one cycle, go to IDLE.
    - start is ignored while in SEND.
- The earliest next start is accepted on the cycle done is high, since the FSM is in IDLE then. Back-to-back packets therefore have a minimum 1-cycle valid gap.
- FIFO rules:
  - A write when full is dropped; count is unchanged.
  - Writes are allowed during SEND.
  - Pop and write on the same edge leave count unchanged. Such a write is accepted even when full, because the pop frees a slot.
  - Pointers wrap modulo DEPTH.
  - No underrun is possible: the packet length is checked against count at start, and later writes only add words.
- data is don't-care-free: it retains its last value when valid=0.

Decomposition:
- avalon_st_pkt_source top contains the FSM, remaining counter and output registers.
- One sub-module, avalon_sync_fifo (params DATA_W, DEPTH).
  - Registered memory, wr/rd pointers, count, full/empty.
  - Combinational read of head word.
- Shared include/package: FSM state encodings (ST_IDLE, ST_SEND) and a CLOG2 helper constant function. No other typedefs are needed.

Test Plan:
- Load 4,5,6; pkt_len=3; start with ready=1 constantly -> data 4(sop),5,6(eop) on three consecutive cycles starting 1 cycle after start; done pulses once; count=0.
- Same load, ready toggling 1,0,0,1,0,1 -> each beat held stable while ready=0; exactly 3 transfers, order 4,5,6; sop only on 4, eop only on 6.
- pkt_len=1 with one word 0xAA -> single beat with sop=1 and eop=1; done next cycle.
- count=2, start with pkt_len=3; also start with pkt_len=0 -> both ignored: valid stays 0, busy=0, no done.
- Fill to DEPTH=16, then a 17th write -> full=1, word dropped. Next, a write coincident with a pop -> count stays 16, wrap-around order preserved across a 16-beat packet.
- Assert resetn=0 mid-packet after 2 of 5 beats -> valid, sop, eop, busy, data all 0 immediately; count=0. After release, a new load and start sends correctly.
